// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider; returns remainder on resp_hi, quotient on resp_lo
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_hi,
  output logic [DATA_W-1:0] resp_lo,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, src1_q, src1_d, hi_q, hi_d, lo_q, lo_d;
  logic              qs_q, qs_d, rs_q, rs_d, dz_q, dz_d;
  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] rem_n, quo_n;
  logic              ge, neg1, neg2;
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    src1_d = src1_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    qs_d   = qs_q;
    rs_d   = rs_q;
    dz_d   = dz_q;
    neg1   = req_signed & req_src1[DATA_W-1];
    neg2   = req_signed & req_src2[DATA_W-1];
    // dividend shifts out its MSB while quotient bits shift into the same register
    part   = {rem_q, dvd_q[DATA_W-1]};
    ge     = part >= {1'b0, dvs_q};
    rem_n  = ge ? DATA_W'(part - {1'b0, dvs_q}) : part[DATA_W-1:0];
    quo_n  = {dvd_q[DATA_W-2:0], ge};
    if (flush) begin
      st_d = IDLE;
    end else if (st_q == IDLE) begin
      if (req_valid) begin
        st_d   = CALC;
        cnt_d  = '0;
        rem_d  = '0;
        dvd_d  = neg1 ? -req_src1 : req_src1;
        dvs_d  = neg2 ? -req_src2 : req_src2;
        qs_d   = neg1 ^ neg2;
        rs_d   = neg1;
        src1_d = req_src1;
        dz_d   = req_src2 == '0;
      end
    end else if (st_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      rem_d = rem_n;
      dvd_d = quo_n;
      if (cnt_q == LAST) begin
        st_d = DONE;
        lo_d = dz_q ? '1 : (qs_q ? -quo_n : quo_n);
        hi_d = dz_q ? src1_q : (rs_q ? -rem_n : rem_n);
      end
    end else if (resp_ready) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      src1_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      qs_q   <= 1'b0;
      rs_q   <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      src1_q <= src1_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      qs_q   <= qs_d;
      rs_q   <= rs_d;
      dz_q   <= dz_d;
    end
  end
  assign req_ready  = st_q == IDLE;
  assign resp_valid = st_q == DONE;
  assign busy       = st_q != IDLE;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: random and directed stimulus against a cycle-level reference of the divider
module tb_div_unit;
  localparam int W = 32;
  logic         clk = 0, resetn = 0, flush = 0, req_valid = 0, req_signed = 0, resp_ready = 1;
  logic [W-1:0] req_src1 = 0, req_src2 = 0;
  logic         req_ready, resp_valid, busy;
  logic [W-1:0] resp_hi, resp_lo;
  int checks = 0, errors = 0;

  div_unit #(.DATA_W(W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_src1(req_src1), .req_src2(req_src2), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_hi(resp_hi), .resp_lo(resp_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {a, {W{1'b1}}};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    end
    return {a % b, a / b};
  endfunction

  // reference: idle / counting down / holding a result
  bit           m_busy, m_valid;
  int           m_left;
  logic [W-1:0] m_hi, m_lo;
  logic [2*W-1:0] p_res;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 0; m_valid <= 0; m_left <= 0; m_hi <= 0; m_lo <= 0; p_res <= 0;
    end else if (flush) begin
      m_busy <= 0; m_valid <= 0; m_left <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1; m_left <= W; p_res <= ref_div(req_signed, req_src1, req_src2);
      end
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1; m_hi <= p_res[2*W-1:W]; m_lo <= p_res[W-1:0];
      end
    end else if (resp_ready) begin
      m_valid <= 0; m_busy <= 0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
    chk("resp_hi", resp_hi, m_hi);
    chk("resp_lo", resp_lo, m_lo);
  end

  task automatic run(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input int hold, input string nm);
    int n = 0;
    req_signed = s; req_src1 = a; req_src2 = b; req_valid = 1;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = (hold > 0);
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_hi"}, resp_hi, eh);
    chk({nm, "_lo"}, resp_lo, el);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, {31'b0, resp_valid}, 1);
      chk({nm, "_hold_ready"}, {31'b0, req_ready}, 0);
      chk({nm, "_hold_lo"}, resp_lo, el);
    end
    resp_ready = 1; req_valid = 0;
    @(posedge clk); #1;
    chk({nm, "_ready_after"}, {31'b0, req_ready}, 1);
  endtask

  initial begin
    logic [2*W-1:0] r;
    logic [W-1:0] a, b;
    r = ref_div(0, 100, 7);                   chk("pin_u100_7", r[W-1:0], 14);
    r = ref_div(1, 32'hFFFF_FFF9, 2);          chk("pin_sm7_2", r[2*W-1:W], 32'hFFFF_FFFF);
    r = ref_div(1, 7, 32'hFFFF_FFFE);          chk("pin_s7_m2", r[W-1:0], 32'hFFFF_FFFD);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_valid", {31'b0, resp_valid}, 0);
    chk("rst_lo", resp_lo, 0);
    resetn = 1;
    @(posedge clk); #1;
    run(0, 100, 7, 2, 14, 0, "u100_7");
    run(1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "sm7_2");
    run(1, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 0, "s7_m2");
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, "ovf");
    run(0, 5, 0, 5, 32'hFFFF_FFFF, 0, "u5_0");
    run(1, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, "sm5_0");
    run(0, 1000, 33, 10, 30, 5, "bp");
    // flush mid-calculation
    req_signed = 0; req_src1 = 50; req_src2 = 4; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_ready", {31'b0, req_ready}, 1);
    repeat (40) begin
      @(posedge clk); #1;
      chk("flush_novalid", {31'b0, resp_valid}, 0);
    end
    run(0, 9, 3, 0, 3, 0, "u9_3");
    // asynchronous reset between edges
    req_signed = 1; req_src1 = 32'hFFFF_FF00; req_src2 = 3; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (10) @(posedge clk);
    #3 resetn = 0;
    #1;
    chk("arst_ready", {31'b0, req_ready}, 1);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_hi", resp_hi, 0);
    chk("arst_lo", resp_lo, 0);
    @(posedge clk); #2 resetn = 1;
    @(posedge clk); #1;
    run(1, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0, "sm100_7");
    // random traffic, the reference follows every cycle
    for (int i = 0; i < 6000; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: begin a = $urandom; b = 32'($signed($urandom_range(0, 40)) - 20); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      req_src1 = a; req_src2 = b;
      req_signed = $urandom_range(0, 1) == 1;
      req_valid = $urandom_range(0, 1) == 1;
      resp_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 199) == 0;
      @(posedge clk); #1;
    end
    flush = 0; req_valid = 0; resp_ready = 1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
